// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-word bit positions, the ID/EX
// stage state type and the NOP control word.
package mips_pipe_pkg;

   localparam int CTRL_W = 25;

   // Control-word bit positions as produced by the ID control unit
   localparam int CTRL_LOAD       = 0;
   localparam int CTRL_MEMTOREG   = 1;
   localparam int CTRL_LOEN       = 2;
   localparam int CTRL_REGWE      = 3;
   localparam int CTRL_HIEN       = 4;
   localparam int CTRL_MEM_MUX    = 5;
   localparam int CTRL_DM_SE      = 6;
   localparam int CTRL_DM_SIZE_LO = 7;
   localparam int CTRL_DM_EN      = 9;
   localparam int CTRL_DM_RW      = 10;
   localparam int CTRL_ALUOP_LO   = 11;
   localparam int CTRL_S0S2_LO    = 15;
   localparam int CTRL_RSADDRMUX  = 18;
   localparam int CTRL_BASEADDR   = 19;
   localparam int CTRL_WDEST_LO   = 20;
   localparam int CTRL_CMUX       = 22;
   localparam int CTRL_JALADDER   = 23;
   localparam int CTRL_JUMP       = 24;

   // All-zero control word: no register, memory or HI/LO side effects
   localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

   // ID/EX stage flow state
   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      HOLD      = 2'd2
   } id_ex_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the instruction in EX is a register-writing load
// to a non-zero register that the real instruction in ID reads.
module load_use_detect #(
   parameter int IDX_W = 5
) (
   input  logic             valid_ex,
   input  logic             load_ex,
   input  logic             regwe_ex,
   input  logic [IDX_W-1:0] dest_idx_ex,
   input  logic             valid_id,
   input  logic             rs_used_id,
   input  logic [IDX_W-1:0] rs_idx_id,
   input  logic             rt_used_id,
   input  logic [IDX_W-1:0] rt_idx_id,
   output logic             hazard_o
);

   logic rs_match;
   logic rt_match;

   // r0 is never written, so a load targeting it can never create a dependency
   always_comb begin
      rs_match = rs_used_id && (rs_idx_id == dest_idx_ex);
      rt_match = rt_used_id && (rt_idx_id == dest_idx_ex);
      hazard_o = valid_ex && load_ex && regwe_ex && (dest_idx_ex != '0) &&
                 valid_id && (rs_match || rt_match);
   end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, global stall and
// branch/jump flush. Define ID_EX_BUBBLE_CNT_EN to add a saturating count of
// inserted load-use bubbles on bubble_cnt_o.
module id_ex_stage_reg #(
   parameter int CTRL_W = 25,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 5
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   parameter int CNT_W  = 32
`endif
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [CTRL_W-1:0] ctrl_id,
   input  logic              valid_id,
   input  logic [DATA_W-1:0] pc8_id,
   input  logic [DATA_W-1:0] rs_data_id,
   input  logic [DATA_W-1:0] rt_data_id,
   input  logic [DATA_W-1:0] imm_id,
   input  logic [IDX_W-1:0]  rs_idx_id,
   input  logic [IDX_W-1:0]  rt_idx_id,
   input  logic [IDX_W-1:0]  dest_idx_id,
   input  logic              rs_used_id,
   input  logic              rt_used_id,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [CTRL_W-1:0] ctrl_ex,
   output logic              valid_ex,
   output logic [DATA_W-1:0] pc8_ex,
   output logic [DATA_W-1:0] rs_data_ex,
   output logic [DATA_W-1:0] rt_data_ex,
   output logic [DATA_W-1:0] imm_ex,
   output logic [IDX_W-1:0]  rt_idx_ex,
   output logic [IDX_W-1:0]  dest_idx_ex,
   output logic              cmux_o,
   output logic              pc_we_o,
   output logic              ifid_we_o
`ifdef ID_EX_BUBBLE_CNT_EN
   ,
   output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

   import mips_pipe_pkg::*;

   id_ex_state_e      state_q, state_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] pc8_q, pc8_d;
   logic [DATA_W-1:0] rs_data_q, rs_data_d;
   logic [DATA_W-1:0] rt_data_q, rt_data_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [IDX_W-1:0]  rt_idx_q, rt_idx_d;
   logic [IDX_W-1:0]  dest_idx_q, dest_idx_d;
   logic              hazard_raw;
   logic              hazard;

   load_use_detect #(.IDX_W(IDX_W)) u_detect (
      .valid_ex    (valid_q),
      .load_ex     (ctrl_q[CTRL_LOAD]),
      .regwe_ex    (ctrl_q[CTRL_REGWE]),
      .dest_idx_ex (dest_idx_q),
      .valid_id    (valid_id),
      .rs_used_id  (rs_used_id),
      .rs_idx_id   (rs_idx_id),
      .rt_used_id  (rt_used_id),
      .rt_idx_id   (rt_idx_id),
      .hazard_o    (hazard_raw)
   );

   // The bubble sitting in EX already clears the equation; gating on the
   // bubble state keeps a single bubble per load-use pair by construction
   always_comb begin
      hazard = hazard_raw && (state_q != LU_BUBBLE);
   end

   // Next-state and hazard-unit outputs; priority is flush, stall, hazard, load
   always_comb begin
      state_d    = stall_i ? HOLD : RUN;
      ctrl_d     = ctrl_q;
      valid_d    = valid_q;
      pc8_d      = pc8_q;
      rs_data_d  = rs_data_q;
      rt_data_d  = rt_data_q;
      imm_d      = imm_q;
      rt_idx_d   = rt_idx_q;
      dest_idx_d = dest_idx_q;
      cmux_o     = 1'b1;
      pc_we_o    = 1'b1;
      ifid_we_o  = 1'b1;
      if (flush_i) begin
         ctrl_d     = CTRL_W'(CTRL_NOP);
         valid_d    = 1'b0;
         pc8_d      = '0;
         rs_data_d  = '0;
         rt_data_d  = '0;
         imm_d      = '0;
         rt_idx_d   = '0;
         dest_idx_d = '0;
      end else if (stall_i) begin
         pc_we_o   = 1'b0;
         ifid_we_o = 1'b0;
      end else if (hazard) begin
         state_d   = LU_BUBBLE;
         ctrl_d    = CTRL_W'(CTRL_NOP);
         valid_d   = 1'b0;
         cmux_o    = 1'b0;
         pc_we_o   = 1'b0;
         ifid_we_o = 1'b0;
      end else begin
         ctrl_d     = ctrl_id;
         valid_d    = valid_id;
         pc8_d      = pc8_id;
         rs_data_d  = rs_data_id;
         rt_data_d  = rt_data_id;
         imm_d      = imm_id;
         rt_idx_d   = rt_idx_id;
         dest_idx_d = dest_idx_id;
      end
   end

   // Stage registers; reset leaves a NOP in EX and the flow state in RUN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= RUN;
         ctrl_q     <= '0;
         valid_q    <= 1'b0;
         pc8_q      <= '0;
         rs_data_q  <= '0;
         rt_data_q  <= '0;
         imm_q      <= '0;
         rt_idx_q   <= '0;
         dest_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         valid_q    <= valid_d;
         pc8_q      <= pc8_d;
         rs_data_q  <= rs_data_d;
         rt_data_q  <= rt_data_d;
         imm_q      <= imm_d;
         rt_idx_q   <= rt_idx_d;
         dest_idx_q <= dest_idx_d;
      end
   end

   assign ctrl_ex     = ctrl_q;
   assign valid_ex    = valid_q;
   assign pc8_ex      = pc8_q;
   assign rs_data_ex  = rs_data_q;
   assign rt_data_ex  = rt_data_q;
   assign imm_ex      = imm_q;
   assign rt_idx_ex   = rt_idx_q;
   assign dest_idx_ex = dest_idx_q;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // Count bubbles actually inserted, sticking at all-ones
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (hazard && !stall_i && !flush_i && (bubble_cnt_q != '1)) begin
         bubble_cnt_d = bubble_cnt_q + 1'b1;
      end
   end

   // Bubble counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed load-use, r0, stall and
// flush scenarios with literal expectations, then randomized traffic compared
// every cycle against a behavioural model of the stage.
module tb_id_ex_stage_reg;

   localparam int CTRL_W    = 25;
   localparam int DATA_W    = 32;
   localparam int IDX_W     = 5;
   localparam int TB_CNT_W  = 3;
   localparam int CNT_MAX   = (1 << TB_CNT_W) - 1;

   logic              clk;
   logic              reset_n;
   logic [CTRL_W-1:0] ctrl_id;
   logic              valid_id;
   logic [DATA_W-1:0] pc8_id, rs_data_id, rt_data_id, imm_id;
   logic [IDX_W-1:0]  rs_idx_id, rt_idx_id, dest_idx_id;
   logic              rs_used_id, rt_used_id, stall_i, flush_i;
   logic [CTRL_W-1:0] ctrl_ex;
   logic              valid_ex;
   logic [DATA_W-1:0] pc8_ex, rs_data_ex, rt_data_ex, imm_ex;
   logic [IDX_W-1:0]  rt_idx_ex, dest_idx_ex;
   logic              cmux_o, pc_we_o, ifid_we_o;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [TB_CNT_W-1:0] bubble_cnt_o;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Model of the EX-side contents
   logic [CTRL_W-1:0] m_ctrl;
   logic              m_valid;
   logic [DATA_W-1:0] m_pc8, m_rs, m_rt, m_imm;
   logic [IDX_W-1:0]  m_rt_idx, m_dest;
   int                m_cnt;

   id_ex_stage_reg #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .CNT_W  (TB_CNT_W)
`endif
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .ctrl_id     (ctrl_id),
      .valid_id    (valid_id),
      .pc8_id      (pc8_id),
      .rs_data_id  (rs_data_id),
      .rt_data_id  (rt_data_id),
      .imm_id      (imm_id),
      .rs_idx_id   (rs_idx_id),
      .rt_idx_id   (rt_idx_id),
      .dest_idx_id (dest_idx_id),
      .rs_used_id  (rs_used_id),
      .rt_used_id  (rt_used_id),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .ctrl_ex     (ctrl_ex),
      .valid_ex    (valid_ex),
      .pc8_ex      (pc8_ex),
      .rs_data_ex  (rs_data_ex),
      .rt_data_ex  (rt_data_ex),
      .imm_ex      (imm_ex),
      .rt_idx_ex   (rt_idx_ex),
      .dest_idx_ex (dest_idx_ex),
      .cmux_o      (cmux_o),
      .pc_we_o     (pc_we_o),
      .ifid_we_o   (ifid_we_o)
`ifdef ID_EX_BUBBLE_CNT_EN
      ,
      .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A load that writes a non-zero register read by the real ID instruction
   function automatic logic model_hazard();
      logic reads;
      reads = (rs_used_id && rs_idx_id == m_dest) || (rt_used_id && rt_idx_id == m_dest);
      return m_valid && m_ctrl[0] && m_ctrl[3] && (m_dest != 0) && valid_id && reads;
   endfunction

   // Behavioural model: flush beats stall beats hazard beats normal load
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ctrl <= '0; m_valid <= 1'b0; m_pc8 <= '0; m_rs <= '0; m_rt <= '0;
         m_imm <= '0; m_rt_idx <= '0; m_dest <= '0; m_cnt <= 0;
      end else if (flush_i) begin
         m_ctrl <= '0; m_valid <= 1'b0; m_pc8 <= '0; m_rs <= '0; m_rt <= '0;
         m_imm <= '0; m_rt_idx <= '0; m_dest <= '0;
      end else if (stall_i) begin
         m_cnt <= m_cnt;
      end else if (model_hazard()) begin
         m_ctrl  <= '0;
         m_valid <= 1'b0;
         m_cnt   <= (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
      end else begin
         m_ctrl <= ctrl_id; m_valid <= valid_id; m_pc8 <= pc8_id; m_rs <= rs_data_id;
         m_rt <= rt_data_id; m_imm <= imm_id; m_rt_idx <= rt_idx_id; m_dest <= dest_idx_id;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every DUT output against the model
   task automatic check_output();
      logic haz;
      logic exp_cmux, exp_we;
      haz      = model_hazard();
      exp_cmux = flush_i || stall_i || !haz;
      exp_we   = flush_i || (!stall_i && !haz);
      check("ctrl_ex", 32'(ctrl_ex), 32'(m_ctrl));
      check("valid_ex", 32'(valid_ex), 32'(m_valid));
      check("pc8_ex", pc8_ex, m_pc8);
      check("rs_data_ex", rs_data_ex, m_rs);
      check("rt_data_ex", rt_data_ex, m_rt);
      check("imm_ex", imm_ex, m_imm);
      check("rt_idx_ex", 32'(rt_idx_ex), 32'(m_rt_idx));
      check("dest_idx_ex", 32'(dest_idx_ex), 32'(m_dest));
      check("cmux_o", 32'(cmux_o), 32'(exp_cmux));
      check("pc_we_o", 32'(pc_we_o), 32'(exp_we));
      check("ifid_we_o", 32'(ifid_we_o), 32'(exp_we));
`ifdef ID_EX_BUBBLE_CNT_EN
      check("bubble_cnt_o", 32'(bubble_cnt_o), 32'(m_cnt));
`endif
   endtask

   // One clock: compare on the falling edge, return just after the rising edge
   task automatic cycle();
      @(negedge clk);
      check_output();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [CTRL_W-1:0] c, input logic v,
                                 input logic [IDX_W-1:0] rs, input logic rsu,
                                 input logic [IDX_W-1:0] rt, input logic rtu,
                                 input logic [IDX_W-1:0] dst);
      ctrl_id = c; valid_id = v; rs_idx_id = rs; rs_used_id = rsu;
      rt_idx_id = rt; rt_used_id = rtu; dest_idx_id = dst;
      pc8_id = $urandom; rs_data_id = $urandom; rt_data_id = $urandom; imm_id = $urandom;
   endtask

   task automatic randomize_inputs(input bit allow_ctl);
      logic [CTRL_W-1:0] c;
      c = CTRL_W'($urandom);
      if ($urandom_range(0, 1) == 1) c = c | 25'h0000009;
      apply_stimulus(c, $urandom_range(0, 4) != 0,
                     IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     IDX_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     IDX_W'($urandom_range(0, 3)));
      stall_i = allow_ctl && ($urandom_range(0, 7) == 0);
      flush_i = allow_ctl && ($urandom_range(0, 11) == 0);
   endtask

   initial begin
      reset_n = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
      randomize_inputs(1'b0);
      #3;
      check("reset ctrl_ex", 32'(ctrl_ex), 32'h0);
      check("reset valid_ex", 32'(valid_ex), 32'h0);
      check("reset cmux_o", 32'(cmux_o), 32'h1);
      check("reset pc_we_o", 32'(pc_we_o), 32'h1);
      check("reset ifid_we_o", 32'(ifid_we_o), 32'h1);
      cycle();
      reset_n = 1'b1;

      // Load-use: LW r5 in EX, consumer reads r5 via rs
      apply_stimulus(25'h0000009, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
      cycle();
      check("lw ctrl_ex", 32'(ctrl_ex), 32'h0000009);
      apply_stimulus(25'h0ABCDE0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b0, 5'd7);
      #1;
      check("lu cmux_o", 32'(cmux_o), 32'h0);
      check("lu pc_we_o", 32'(pc_we_o), 32'h0);
      check("lu ifid_we_o", 32'(ifid_we_o), 32'h0);
      cycle();
      check("bubble ctrl_ex", 32'(ctrl_ex), 32'h0);
      check("bubble valid_ex", 32'(valid_ex), 32'h0);
      check("after bubble cmux_o", 32'(cmux_o), 32'h1);
      cycle();
      check("reissue ctrl_ex", 32'(ctrl_ex), 32'h0ABCDE0);
      check("reissue dest_idx_ex", 32'(dest_idx_ex), 32'h7);

      // r0 destination never stalls
      apply_stimulus(25'h0000009, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
      cycle();
      apply_stimulus(25'h0000100, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3);
      #1;
      check("r0 cmux_o", 32'(cmux_o), 32'h1);
      cycle();
      check("r0 ctrl_ex", 32'(ctrl_ex), 32'h0000100);

      // Matching indices but no register reads
      apply_stimulus(25'h0000009, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
      cycle();
      apply_stimulus(25'h0000200, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd4);
      #1;
      check("nouse pc_we_o", 32'(pc_we_o), 32'h1);
      cycle();
      check("nouse ctrl_ex", 32'(ctrl_ex), 32'h0000200);

      // Three-cycle stall with a changing control word
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(CTRL_W'(25'h0001000 + i), 1'b1, 5'd1, 1'b0, 5'd1, 1'b0, 5'd2);
         #1;
         check("stall pc_we_o", 32'(pc_we_o), 32'h0);
         check("stall cmux_o", 32'(cmux_o), 32'h1);
         cycle();
         check("stall ctrl_ex", 32'(ctrl_ex), 32'h0000200);
      end
      stall_i = 1'b0;
      apply_stimulus(25'h1FFFF00, 1'b1, 5'd1, 1'b0, 5'd1, 1'b0, 5'd2);
      #1;
      check("resume pc_we_o", 32'(pc_we_o), 32'h1);
      cycle();
      check("resume ctrl_ex", 32'(ctrl_ex), 32'h1FFFF00);

      // Flush beats stall and hazard
      apply_stimulus(25'h0000009, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5);
      cycle();
      apply_stimulus(25'h0000040, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
      stall_i = 1'b1;
      flush_i = 1'b1;
      cycle();
      check("flush ctrl_ex", 32'(ctrl_ex), 32'h0);
      check("flush valid_ex", 32'(valid_ex), 32'h0);
      stall_i = 1'b0;
      flush_i = 1'b0;

      // Randomized traffic with occasional asynchronous reset pulses
      for (int n = 0; n < 3000; n++) begin
         randomize_inputs(1'b1);
         reset_n = ($urandom_range(0, 99) != 0);
         cycle();
      end
      reset_n = 1'b1;
      cycle();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register, sitting directly downstream of the ID-stage control unit and its control-word mux.
- Latches the 25-bit control word plus operands/indices into EX.
- Detects load-use hazards, and on a hazard:
  - inserts exactly one bubble;
  - drives the CMUX select back to ID (0 = zero the control word);
  - freezes PC and IF/ID.
- Also handles global stall and branch/jump flush.

Parameters:
- CTRL_W, 25, control word width (bit map fixed below)
- DATA_W, 32, datapath width
- IDX_W, 5, register index width
- CNT_W, 32, bubble counter width (optional feature only)

Ports:
- clk  in  1  pipeline clock
- reset_n  in  1  async active-low reset
- ctrl_id  in  CTRL_W  control word from the ID control-word mux. Bit map: 0 Load, 1 MemtoReg, 2 LoEnable, 3 RegFileEnable, 4 HiEnable, 5 MEM_MUX, 6 Data_Mem_SE, 8:7 Data_Mem_Size, 9 Data_Mem_Enable, 10 Data_Mem_RW, 14:11 ALUOp, 17:15 S0_S2, 18 RsAddrMux, 19 Base_Addr_MUX, 21:20 WriteDestination, 22 CMUX, 23 JalAdder, 24 Jump
- valid_id  in  1  ID holds a real instruction
- pc8_id  in  DATA_W  PC+8 for link instructions
- rs_data_id, rt_data_id, imm_id  in  DATA_W  operands / extended immediate
- rs_idx_id, rt_idx_id, dest_idx_id  in  IDX_W  source indices; resolved destination index (rd/rt/31)
- rs_used_id, rt_used_id  in  1  instruction reads rs / rt
- stall_i  in  1  global hold from EX/MEM
- flush_i  in  1  redirect (taken branch/jump); kill the ID instruction
- ctrl_ex  out  CTRL_W  registered control word
- valid_ex  out  1  registered valid
- pc8_ex, rs_data_ex, rt_data_ex, imm_ex  out  DATA_W  registered data
- rt_idx_ex, dest_idx_ex  out  IDX_W  registered indices
- cmux_o  out  1  to ID control-word mux; 0 = insert bubble
- pc_we_o, ifid_we_o  out  1  PC / IF/ID write enables
- bubble_cnt_o  out  CNT_W  only with the optional feature

Behaviour:
- Reset (async, reset_n=0):
  - All registered outputs are 0; ctrl_ex=0 is a NOP.
  - FSM goes to RUN.
  - Combinational outputs with the EX stage empty: cmux_o=1, pc_we_o=1, ifid_we_o=1.
- hazard (combinational) = valid_ex & ctrl_ex[0] & ctrl_ex[3] & (dest_idx_ex!=0) & valid_id & ((rs_used_id & rs_idx_id==dest_idx_ex) | (rt_used_id & rt_idx_id==dest_idx_ex)).
- FSM states:
  - RUN: normal flow.
  - LU_BUBBLE: the bubble cycle after a load-use detection.
  - HOLD: stall_i asserted.
- Transitions:
  - RUN -> HOLD on stall_i.
  - RUN -> LU_BUBBLE on hazard & !stall_i & !flush_i.
  - LU_BUBBLE -> RUN unconditionally, unless stall_i (-> HOLD).
  - HOLD -> RUN when stall_i=0.
- Per-edge update priority:
  - flush_i: ctrl_ex<=0, valid_ex<=0, data don't-care (cleared to 0). Flush beats stall_i and hazard.
  - else stall_i: all ID/EX registers hold; pc_we_o=ifid_we_o=0; cmux_o=1.
  - else hazard: ctrl_ex<=0, valid_ex<=0; cmux_o=0; pc_we_o=ifid_we_o=0. The ID instruction is re-presented next cycle.
  - else: load all *_id inputs; ctrl_ex<=ctrl_id, valid_ex<=valid_id.
- cmux_o, pc_we_o and ifid_we_o are combinational from current state and inputs, valid in the same cycle.
- Load-use costs exactly 1 bubble. The bubble in EX clears hazard, so no back-to-back bubbles for the same pair.
- dest_idx_ex=0 never triggers a hazard, because r0 is never written.
- Reset mid-stall or mid-bubble: immediate return to the reset values. No pending bubble survives.
- Widths are fixed; no arithmetic except the optional counter.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt_o increments by 1 on each edge where hazard & !stall_i & !flush_i.
  - Saturates at all-ones.
  - Reset to 0.
- Undefined: the port and counter are absent.

Decomposition:
- Shared package mips_pipe_pkg:
  - CTRL_W;
  - control-bit index constants (CTRL_LOAD=0, CTRL_REGWE=3, CTRL_CMUX=22, ...);
  - FSM state enum {RUN, LU_BUBBLE, HOLD};
  - NOP control word constant = 0.
- One sub-module: load_use_detect (pure combinational hazard equation).

Test Plan:
- Reset: reset_n=0 with random inputs -> ctrl_ex=0, valid_ex=0, cmux_o=1, pc_we_o=1.
- Load-use: LW with dest 5 in EX (ctrl_ex[0]=1, [3]=1), ID has rs_idx=5, rs_used=1 -> cmux_o=0, pc_we_o=0, next ctrl_ex=0; the following cycle the ID instruction latches normally.
- r0 / no-use: LW with dest 0 in EX and rs_idx=0 -> no bubble. Same dest 5 with rs_used=0, rt_used=0 -> no bubble.
- Stall: stall_i=1 for 3 cycles with ctrl_id changing -> ctrl_ex holds its value; pc_we_o=0 throughout; resumes on cycle 4.
- Flush priority: flush_i=1 together with stall_i=1 and hazard=1 -> ctrl_ex=0, valid_ex=0 next edge.
- Counter (ID_EX_BUBBLE_CNT_EN): 4 load-use events with a stall interleaved -> bubble_cnt_o=4. Preload near all-ones -> saturates.
